delay_sensor_ctrl: RTL
======================

DELAY_SENSOR_CTRL -- requirements
Module: delay_sensor_ctrl

Interface
REQ-001 The block SHALL have parameter N_TAPS, default 8, giving the number of delay-chain taps sampled (2..16).
REQ-002 The block SHALL have parameter CODE_W, default 5, giving the code width, which must hold 0..N_TAPS.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; the tap inputs are sampled on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle request to begin a measurement; it is honoured only in IDLE.
REQ-006 The block SHALL have port window_len, input, 8 bits: the number of MEASURE cycles, latched on an accepted start.
REQ-007 The block SHALL have port tap, input, N_TAPS bits: the delay-chain tap outputs; tap[0] is the shortest delay.
REQ-008 The block SHALL have port sensor_en, output, 1 bit: it enables the delay chain.
REQ-009 The block SHALL have port busy, output, 1 bit: it is high in any state other than IDLE.
REQ-010 The block SHALL have ports min_code and max_code, output, CODE_W bits each: the extreme codes seen in the window.
REQ-011 The block SHALL have port bubble_cnt, output, 8 bits: the number of non-thermometer samples, saturating at 255.
REQ-012 The block SHALL have port result_valid, output, 1 bit, and port result_ready, input, 1 bit, forming the result handshake.

Function
REQ-013 The FSM SHALL have states IDLE, SETTLE, MEASURE and REPORT, and SHALL move IDLE->SETTLE on start while in IDLE.
REQ-014 SETTLE SHALL last exactly 2 cycles, with sensor_en=1 and no samples evaluated.
REQ-015 MEASURE SHALL last exactly window_len cycles, or 256 cycles when window_len=0, with sensor_en=1.
REQ-016 Every cycle, tap SHALL be registered into tap_q; each MEASURE cycle evaluates the tap_q value registered on the previous edge.
REQ-017 Code SHALL be the count of consecutive ones starting at tap_q[0], with range 0..N_TAPS.
REQ-018 A sample SHALL be a bubble if any 1 lies above the first 0; its code still counts, and bubble_cnt increments, saturating at 255.
REQ-019 At SETTLE->MEASURE, min_code SHALL initialise to N_TAPS and max_code to 0; each MEASURE sample then updates them by compare.
REQ-020 After the last MEASURE cycle the FSM SHALL enter REPORT, with sensor_en=0 and result_valid=1.
REQ-021 Result outputs SHALL be held stable while result_valid=1; a transfer occurs on a cycle where result_valid and result_ready are both 1.
REQ-022 On transfer the FSM SHALL go REPORT->IDLE, and result_valid SHALL be 0 on the next cycle.
REQ-023 start asserted outside IDLE SHALL be ignored, and changes to window_len outside an accepted start SHALL be ignored.
REQ-024 With result_ready held 1, the total latency from start to result_valid SHALL be 1+2+window_len cycles.

Reset
REQ-025 While rst=1 at a clock edge, the FSM SHALL go to IDLE and tap_q SHALL clear; this includes reset in mid-SETTLE, MEASURE or REPORT.
REQ-026 The reset values SHALL be sensor_en=0, busy=0, result_valid=0, min_code=0, max_code=0, bubble_cnt=0.
REQ-027 An aborted measurement SHALL produce no result, and start in the first cycle after rst deasserts SHALL be honoured.

Configuration
REQ-028 The macro SENSOR_CTRL_CONTINUOUS_EN SHALL control auto-restart.
REQ-029 When SENSOR_CTRL_CONTINUOUS_EN is defined, a transfer in REPORT SHALL go directly to SETTLE, reusing the latched window_len, and busy SHALL stay 1.
REQ-030 In continuous mode, the controller SHALL return to IDLE only via rst.
REQ-031 When SENSOR_CTRL_CONTINUOUS_EN is undefined, REQ-022 SHALL apply unchanged.

Verification
REQ-032 Bench: rst, then start with window_len=4 and tap=8'b00011111 constant -> result_valid 7 cycles after start, min_code=5, max_code=5, bubble_cnt=0.
REQ-033 Bench: window_len=3 with taps 0x07, 0x3F, 0x01 presented so they are evaluated in consecutive MEASURE cycles -> min_code=1, max_code=6.
REQ-034 Bench: window_len=2 and tap=8'b00101111 -> bubble_cnt=2, min_code=4, max_code=4.
REQ-035 Bench: result_ready=0 for 5 cycles in REPORT -> result_valid stays 1 with outputs unchanged; ready=1 -> IDLE next cycle.
REQ-036 Bench: rst pulsed in MEASURE cycle 2 of 10 -> all outputs at reset values, no result_valid; a later start completes normally.
REQ-037 Bench: with SENSOR_CTRL_CONTINUOUS_EN, window_len=1 and result_ready=1 -> result_valid pulses every 4 cycles and sensor_en=0 only in REPORT.

Source files
------------

// File: rtl/delay_sensor_ctrl.sv
// Delay-chain sensor controller: settles the chain, measures thermometer codes over a window,
// and reports min/max code and bubble count. Define SENSOR_CTRL_CONTINUOUS_EN for auto-restart.
module delay_sensor_ctrl #(
   parameter int unsigned N_TAPS = 8,
   parameter int unsigned CODE_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        window_len,
   input  logic [N_TAPS-1:0] tap,
   output logic              sensor_en,
   output logic              busy,
   output logic [CODE_W-1:0] min_code,
   output logic [CODE_W-1:0] max_code,
   output logic [7:0]        bubble_cnt,
   output logic              result_valid,
   input  logic              result_ready
);

   typedef enum logic [1:0] {StIdle, StSettle, StMeasure, StReport} state_e;

   state_e              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [7:0]          win_q, win_d;
   logic [N_TAPS-1:0]   tap_q;
   logic [CODE_W-1:0]   min_q, min_d;
   logic [CODE_W-1:0]   max_q, max_d;
   logic [7:0]          bub_q, bub_d;

   logic [CODE_W-1:0]   code;
   logic                bubble;
   logic                found_zero;

   // Code is the run of ones from tap_q[0]; any one above the first zero marks a bubble.
   always_comb begin
      code       = '0;
      bubble     = 1'b0;
      found_zero = 1'b0;
      for (int unsigned i = 0; i < N_TAPS; i++) begin
         if (!found_zero) begin
            if (tap_q[i]) begin
               code = code + CODE_W'(1);
            end else begin
               found_zero = 1'b1;
            end
         end else if (tap_q[i]) begin
            bubble = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      win_d   = win_q;
      min_d   = min_q;
      max_d   = max_q;
      bub_d   = bub_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StSettle;
               cnt_d   = 8'd1;
               win_d   = window_len;
            end
         end
         StSettle: begin
            if (cnt_q == 8'd0) begin
               state_d = StMeasure;
               // window_len of 0 wraps to 255, giving 256 measure cycles
               cnt_d   = win_q - 8'd1;
               min_d   = CODE_W'(N_TAPS);
               max_d   = '0;
               bub_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StMeasure: begin
            if (code < min_q) min_d = code;
            if (code > max_q) max_d = code;
            if (bubble && (bub_q != 8'hFF)) bub_d = bub_q + 8'd1;
            if (cnt_q == 8'd0) begin
               state_d = StReport;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StReport: begin
            if (result_ready) begin
`ifdef SENSOR_CTRL_CONTINUOUS_EN
               state_d = StSettle;
               cnt_d   = 8'd1;
`else
               state_d = StIdle;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 8'd0;
         win_q   <= 8'd0;
         tap_q   <= '0;
         min_q   <= '0;
         max_q   <= '0;
         bub_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         win_q   <= win_d;
         tap_q   <= tap;
         min_q   <= min_d;
         max_q   <= max_d;
         bub_q   <= bub_d;
      end
   end

   assign sensor_en    = (state_q == StSettle) || (state_q == StMeasure);
   assign busy         = (state_q != StIdle);
   assign result_valid = (state_q == StReport);
   assign min_code     = min_q;
   assign max_code     = max_q;
   assign bubble_cnt   = bub_q;

endmodule
